// File: rtl/recepcao_serial_automatica.sv
// 7O1 serial receiver for elevator commands. Sorts frames into a queue buffer
// (15 records) and a content buffer (7 records), with sticky error flags.
//
// state    | meaning
// OCIOSO   | line idle, waiting for a synchronized 0
// INICIO   | confirm the start bit at half a bit time
// DADOS    | shift in d0..d6, LSB first
// PARIDADE | sample the odd parity bit
// PARADA   | sample the stop bit
// ARMAZENA | decode and store the record, single cycle
module recepcao_serial_automatica #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       RX,
  input  logic       limpa,
  input  logic [3:0] addr_fila,
  input  logic [3:0] addr_conteudo,
  output logic [5:0] dados_fila,
  output logic [3:0] dados_conteudo,
  output logic [3:0] num_fila,
  output logic [3:0] num_conteudo,
  output logic       fim_fila,
  output logic       fim_conteudo,
  output logic       pronto,
  output logic       erro_paridade,
  output logic       erro_formato,
  output logic       erro_parada,
  output logic [2:0] db_estado
);

  localparam int TW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    INICIO   = 3'd1,
    DADOS    = 3'd2,
    PARIDADE = 3'd3,
    PARADA   = 3'd4,
    ARMAZENA = 3'd5
  } estado_t;

  estado_t       estado, prox_estado;
  logic          rx_m, rx_s;
  logic [TW-1:0] timer;
  logic          tc;
  logic [2:0]    bit_idx;
  logic [6:0]    shreg;
  logic          par_ok;
  logic [5:0]    fila_mem [16];
  logic [3:0]    cont_mem [8];
  logic          grava_fila, grava_conteudo, formato_ruim;

  assign tc = (timer == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= RX;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= OCIOSO;
    else        estado <= prox_estado;
  end

  always_comb begin
    prox_estado = estado;
    case (estado)
      OCIOSO:   if (!rx_s) prox_estado = INICIO;
      INICIO:   if (tc) prox_estado = rx_s ? OCIOSO : DADOS;
      DADOS:    if (tc && bit_idx == 3'd6) prox_estado = PARIDADE;
      PARIDADE: if (tc) prox_estado = PARADA;
      PARADA:   if (tc) prox_estado = rx_s ? ARMAZENA : OCIOSO;
      ARMAZENA: prox_estado = OCIOSO;
      default:  prox_estado = OCIOSO;
    endcase
    if (limpa) prox_estado = OCIOSO;
  end

  // Full buffers drop the record silently: no pronto, no flag.
  always_comb begin
    grava_fila     = 1'b0;
    grava_conteudo = 1'b0;
    formato_ruim   = 1'b0;
    if (estado == ARMAZENA && par_ok && !limpa) begin
      if (!shreg[6])                 grava_fila     = (num_fila != 4'd15);
      else if (shreg[6:4] == 3'b111) grava_conteudo = (num_conteudo != 4'd7);
      else                           formato_ruim   = 1'b1;
    end
  end

  assign pronto = grava_fila | grava_conteudo;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timer         <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      par_ok        <= 1'b0;
      num_fila      <= '0;
      num_conteudo  <= '0;
      erro_paridade <= 1'b0;
      erro_formato  <= 1'b0;
      erro_parada   <= 1'b0;
      for (int i = 0; i < 16; i++) fila_mem[i] <= '0;
      for (int i = 0; i < 8; i++)  cont_mem[i] <= '0;
    end else if (limpa) begin
      timer         <= '0;
      bit_idx       <= '0;
      par_ok        <= 1'b0;
      num_fila      <= '0;
      num_conteudo  <= '0;
      erro_paridade <= 1'b0;
      erro_formato  <= 1'b0;
      erro_parada   <= 1'b0;
      for (int i = 0; i < 16; i++) fila_mem[i] <= '0;
      for (int i = 0; i < 8; i++)  cont_mem[i] <= '0;
    end else begin
      case (estado)
        OCIOSO: begin
          timer   <= T_HALF;
          bit_idx <= '0;
        end
        INICIO, PARIDADE, PARADA: begin
          timer <= tc ? T_FULL : timer - 1'b1;
          if (estado == PARIDADE && tc) par_ok <= ^{rx_s, shreg};
          if (estado == PARADA && tc && !rx_s) erro_parada <= 1'b1;
        end
        DADOS: begin
          if (tc) begin
            timer   <= T_FULL;
            shreg   <= {rx_s, shreg[6:1]};
            bit_idx <= bit_idx + 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ARMAZENA: begin
          if (!par_ok)  erro_paridade <= 1'b1;
          if (formato_ruim) erro_formato <= 1'b1;
          if (grava_fila) begin
            fila_mem[num_fila] <= shreg[5:0];
            num_fila           <= num_fila + 1'b1;
          end
          if (grava_conteudo) begin
            cont_mem[num_conteudo[2:0]] <= shreg[3:0];
            num_conteudo                <= num_conteudo + 1'b1;
          end
        end
        default: timer <= '0;
      endcase
    end
  end

  assign dados_fila     = fila_mem[addr_fila];
  assign dados_conteudo = addr_conteudo[3] ? 4'd0 : cont_mem[addr_conteudo[2:0]];
  assign fim_fila       = (num_fila == 4'd15);
  assign fim_conteudo   = (num_conteudo == 4'd7);
  assign db_estado      = estado;

endmodule

// File: tb/tb_recepcao_serial_automatica.sv
// Directed bench for recepcao_serial_automatica with a short bit time.
module tb_recepcao_serial_automatica;

  localparam int CPB = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       RX = 1'b1;
  logic       limpa = 1'b0;
  logic [3:0] addr_fila = '0;
  logic [3:0] addr_conteudo = '0;
  logic [5:0] dados_fila;
  logic [3:0] dados_conteudo;
  logic [3:0] num_fila, num_conteudo;
  logic       fim_fila, fim_conteudo, pronto;
  logic       erro_paridade, erro_formato, erro_parada;
  logic [2:0] db_estado;

  int tests = 0;
  int fails = 0;
  int pronto_cnt = 0;
  int p0;

  recepcao_serial_automatica #(.CLKS_PER_BIT(CPB)) dut (
    .clock(clock), .reset(reset), .RX(RX), .limpa(limpa),
    .addr_fila(addr_fila), .addr_conteudo(addr_conteudo),
    .dados_fila(dados_fila), .dados_conteudo(dados_conteudo),
    .num_fila(num_fila), .num_conteudo(num_conteudo),
    .fim_fila(fim_fila), .fim_conteudo(fim_conteudo), .pronto(pronto),
    .erro_paridade(erro_paridade), .erro_formato(erro_formato),
    .erro_parada(erro_parada), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (pronto) pronto_cnt++;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    RX = b;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic frame(input logic [6:0] d, input logic par, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 7; i++) drive_bit(d[i]);
    drive_bit(par);
    drive_bit(stop);
    RX = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic do_limpa();
    limpa = 1'b1;
    @(negedge clock);
    limpa = 1'b0;
    @(negedge clock);
  endtask

  logic [5:0] rec [16];

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_estado", 16'(db_estado), 16'd0);
    chk("rst_num_fila", 16'(num_fila), 16'd0);
    chk("rst_num_cont", 16'(num_conteudo), 16'd0);
    chk("rst_flags", 16'({erro_paridade, erro_formato, erro_parada, pronto}), 16'd0);
    chk("rst_dados", 16'({dados_fila, dados_conteudo}), 16'd0);
    reset = 1'b1;
    repeat (3) @(negedge clock);

    p0 = pronto_cnt;
    frame(7'b0101101, 1'b1, 1'b1);
    chk("q_pronto", 16'(pronto_cnt - p0), 16'd1);
    chk("q_num", 16'(num_fila), 16'd1);
    chk("q_dados", 16'(dados_fila), 16'b101101);
    chk("q_flags", 16'({erro_paridade, erro_formato, erro_parada}), 16'd0);

    frame(7'b1111010, 1'b0, 1'b1);
    chk("c_pronto", 16'(pronto_cnt - p0), 16'd2);
    chk("c_num", 16'(num_conteudo), 16'd1);
    chk("c_dados", 16'(dados_conteudo), 16'b1010);
    chk("c_num_fila", 16'(num_fila), 16'd1);

    frame(7'b0101101, 1'b0, 1'b1);
    chk("par_flag", 16'(erro_paridade), 16'd1);
    chk("par_pronto", 16'(pronto_cnt - p0), 16'd2);
    chk("par_counts", 16'({num_fila, num_conteudo}), 16'h11);

    frame(7'b1011010, 1'b1, 1'b1);
    chk("fmt_flag", 16'(erro_formato), 16'd1);
    chk("fmt_counts", 16'({num_fila, num_conteudo}), 16'h11);

    frame(7'b0101101, 1'b1, 1'b0);
    repeat (12 * CPB) @(negedge clock);
    chk("stop_flag", 16'(erro_parada), 16'd1);
    chk("stop_num", 16'(num_fila), 16'd1);
    chk("stop_pronto", 16'(pronto_cnt - p0), 16'd2);

    do_limpa();
    chk("limpa_counts", 16'({num_fila, num_conteudo}), 16'h00);
    chk("limpa_flags", 16'({erro_paridade, erro_formato, erro_parada}), 16'd0);
    chk("limpa_dados", 16'({dados_fila, dados_conteudo}), 16'd0);

    p0 = pronto_cnt;
    RX = 1'b0;
    repeat (CPB / 4) @(negedge clock);
    RX = 1'b1;
    repeat (3 * CPB) @(negedge clock);
    chk("glitch_estado", 16'(db_estado), 16'd0);
    chk("glitch_flags", 16'({erro_paridade, erro_formato, erro_parada}), 16'd0);
    chk("glitch_pronto", 16'(pronto_cnt - p0), 16'd0);

    for (int i = 0; i < 16; i++) rec[i] = 6'((i * 5 + 3) & 63);
    for (int i = 0; i < 16; i++) begin
      frame({1'b0, rec[i]}, ~^rec[i], 1'b1);
      if (i == 13) chk("full_fim_14", 16'(fim_fila), 16'd0);
      if (i == 14) begin
        chk("full_fim_15", 16'(fim_fila), 16'd1);
        chk("full_num_15", 16'(num_fila), 16'd15);
      end
    end
    chk("full_num_16", 16'(num_fila), 16'd15);
    chk("full_pronto", 16'(pronto_cnt - p0), 16'd15);
    addr_fila = 4'd14;
    #1 chk("full_entry14", 16'(dados_fila), 16'(rec[14]));
    addr_fila = 4'd15;
    #1 chk("full_entry15", 16'(dados_fila), 16'd0);
    addr_fila = 4'd3;
    #1 chk("full_entry3", 16'(dados_fila), 16'(rec[3]));

    p0 = pronto_cnt;
    for (int i = 0; i < 8; i++) frame({3'b111, 4'(i + 1)}, ~^(3'd7 ^ 3'd0) ^ ^4'(i + 1), 1'b1);
    chk("cfull_num", 16'(num_conteudo), 16'd7);
    chk("cfull_fim", 16'(fim_conteudo), 16'd1);
    chk("cfull_pronto", 16'(pronto_cnt - p0), 16'd7);
    addr_conteudo = 4'd6;
    #1 chk("cfull_entry6", 16'(dados_conteudo), 16'd7);
    chk("cfull_flags", 16'({erro_paridade, erro_formato, erro_parada}), 16'd0);

    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    repeat (CPB / 2) @(negedge clock);
    chk("mid_estado", 16'(db_estado), 16'd2);
    reset = 1'b0;
    RX = 1'b1;
    #1;
    chk("mid_rst_estado", 16'(db_estado), 16'd0);
    chk("mid_rst_counts", 16'({num_fila, num_conteudo, 3'b000, fim_fila, fim_conteudo}), 16'd0);
    chk("mid_rst_dados", 16'({dados_fila, dados_conteudo, pronto}), 16'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (3 * CPB) @(negedge clock);
    addr_conteudo = 4'd0;
    p0 = pronto_cnt;
    frame(7'b1111010, 1'b0, 1'b1);
    chk("post_rst_num", 16'(num_conteudo), 16'd1);
    chk("post_rst_dados", 16'(dados_conteudo), 16'b1010);
    chk("post_rst_pronto", 16'(pronto_cnt - p0), 16'd1);
    chk("post_rst_flags", 16'({erro_paridade, erro_formato, erro_parada}), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
